// File: rtl/spi_slave.sv
// SPI target endpoint. The external sclk/ss/mosi lines are oversampled by
// clk, so the whole block runs in one clock domain. All four CPOL/CPHA modes
// are supported. Local logic sees a single-entry TX buffer and a held RX byte
// that must be acknowledged.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  ss_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_d;
    logic                    ss_d;
    logic                    cpol_l;
    logic                    cpha_l;
    logic [DATA_W-1:0]       tx_buf;
    logic [DATA_W-1:0]       tx_shift;
    logic [DATA_W-1:0]       rx_shift;
    logic [CNT_W-1:0]        bit_cnt;

    logic              sclk_s;
    logic              ss_s;
    logic              mosi_s;
    logic              leading_edge;
    logic              trailing_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic              ss_fall;
    logic              ss_rise;
    logic              last_bit;
    logic              byte_done;
    logic              buf_copy;
    logic [DATA_W-1:0] rx_byte;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Edge decode relative to the idle level latched at the start of a transfer
    always_comb begin
        leading_edge  = (sclk_d == cpol_l) && (sclk_s != cpol_l);
        trailing_edge = (sclk_d != cpol_l) && (sclk_s == cpol_l);
        sample_edge   = cpha_l ? trailing_edge : leading_edge;
        shift_edge    = cpha_l ? leading_edge : trailing_edge;
        ss_fall       = ss_d && !ss_s;
        ss_rise       = !ss_d && ss_s;
        last_bit      = (bit_cnt == CNT_W'(DATA_W - 1));
        byte_done     = (state == ACTIVE) && !ss_rise && sample_edge && last_bit;
        buf_copy      = ((state == IDLE) && ss_fall) || byte_done;
        rx_byte       = {rx_shift[DATA_W-2:0], mosi_s};
    end

    // Synchronizer chains plus one extra flop on sclk and ss for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // Transfer FSM, shift registers, TX buffer and RX handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            tx_buf   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            tx_ready <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        cpol_l   <= cpol;
                        cpha_l   <= cpha;
                        tx_shift <= tx_buf;
                        bit_cnt  <= '0;
                        state    <= ACTIVE;
                        miso_oe  <= 1'b1;
                        busy     <= 1'b1;
                        if (!cpha) begin
                            miso <= tx_buf[DATA_W-1];
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_byte;
                        if (last_bit) begin
                            bit_cnt  <= '0;
                            rx_data  <= rx_byte;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ack) begin
                                overrun <= 1'b1;
                            end
                            tx_shift <= tx_buf;
                            if (!cpha_l) begin
                                miso <= tx_buf[DATA_W-1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        if (cpha_l) begin
                            miso     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end else if (bit_cnt != '0) begin
                            miso     <= tx_shift[DATA_W-2];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (buf_copy) begin
                tx_ready <= 1'b1;
            end
            if (tx_load && (tx_ready || buf_copy)) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives an SPI master model at 8 clk per sclk phase,
// queues the bytes each side should receive and compares them as they appear.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 80;

    logic       clk;
    logic       rst;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       overrun;

    int         checks;
    int         errors;
    logic [7:0] expMaster[$];
    logic [7:0] expRx[$];
    logic [7:0] txBytes[4];
    time        lastSampleTime;
    time        rxRiseTime;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss(ss),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
        .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .overrun(overrun)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timestamp every rising edge of rx_valid for the latency check
    always @(posedge rx_valid) rxRiseTime = $time;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic loadTx(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic ackRx();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checkOutput("rxValidAfterAck", rx_valid, 1'b0);
    endtask

    task automatic setMode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        #(HALF);
    endtask

    // Master side of one byte (or a partial byte), MSB first
    task automatic spiByte(input logic [7:0] d, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = d[i];
                #(HALF);
                r = {r[6:0], miso};
                lastSampleTime = $time;
                sclk = ~cpol;
                #(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = d[i];
                #(HALF);
                r = {r[6:0], miso};
                lastSampleTime = $time;
                sclk = cpol;
                #(HALF);
            end
        end
    endtask

    // Full transfer of n bytes from txBytes under one ss assertion
    task automatic applyStimulus(input int n);
        logic [7:0] r;
        logic [7:0] e;
        ss = 1'b0;
        #(HALF);
        checkOutput("misoOeActive", miso_oe, 1'b1);
        checkOutput("busyActive", busy, 1'b1);
        for (int k = 0; k < n; k++) begin
            spiByte(txBytes[k], 8, r);
            if (expMaster.size() == 0) begin
                checkOutput("masterQueueEmpty", expMaster.size(), 1);
            end else begin
                e = expMaster.pop_front();
                checkOutput("masterRx", r, e);
            end
        end
        #(HALF);
        ss = 1'b1;
        #(HALF);
        checkOutput("misoOeIdle", miso_oe, 1'b0);
        checkOutput("busyIdle", busy, 1'b0);
    endtask

    task automatic checkRx();
        logic [7:0] e;
        checkOutput("rxValid", rx_valid, 1'b1);
        if (expRx.size() == 0) begin
            checkOutput("rxQueueEmpty", expRx.size(), 1);
        end else begin
            e = expRx.pop_front();
            checkOutput("rxData", rx_data, e);
        end
    endtask

    // Test sequence
    initial begin
        logic [7:0] r;
        int         cnt;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cpol = 1'b0;
        cpha = 1'b0;
        sclk = 1'b0;
        ss = 1'b1;
        mosi = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        rx_ack = 1'b0;
        lastSampleTime = 0;
        rxRiseTime = 0;
        #1;
        checkOutput("rstMiso", miso, 1'b0);
        checkOutput("rstMisoOe", miso_oe, 1'b0);
        checkOutput("rstTxReady", tx_ready, 1'b1);
        checkOutput("rstRxData", rx_data, 8'h00);
        checkOutput("rstRxValid", rx_valid, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstOverrun", overrun, 1'b0);
        #29;
        rst = 1'b0;
        #40;

        $display("[TB] mode 0 transfer");
        setMode(1'b0, 1'b0);
        loadTx(8'h3C);
        checkOutput("txReadyAfterLoad", tx_ready, 1'b0);
        expMaster.push_back(8'h3C);
        expRx.push_back(8'hA5);
        txBytes[0] = 8'hA5;
        applyStimulus(1);
        checkRx();
        checkOutput("rxLatency",
                    (rxRiseTime > lastSampleTime) && (rxRiseTime - lastSampleTime <= 40), 1'b1);
        checkOutput("txReadyAfterCopy", tx_ready, 1'b1);
        ackRx();

        $display("[TB] mode 3 transfer");
        setMode(1'b1, 1'b1);
        loadTx(8'h81);
        checkOutput("misoOeBefore", miso_oe, 1'b0);
        expMaster.push_back(8'h81);
        expRx.push_back(8'h7E);
        txBytes[0] = 8'h7E;
        applyStimulus(1);
        checkRx();
        ackRx();

        $display("[TB] mode 1 back-to-back");
        setMode(1'b0, 1'b1);
        loadTx(8'h11);
        expMaster.push_back(8'h11);
        expMaster.push_back(8'h22);
        expRx.push_back(8'hF0);
        expRx.push_back(8'h0F);
        txBytes[0] = 8'hF0;
        txBytes[1] = 8'h0F;
        fork
            applyStimulus(2);
            begin
                cnt = 0;
                while (!tx_ready && cnt < 200) begin
                    @(negedge clk);
                    cnt++;
                end
                checkOutput("txReadyRise", tx_ready, 1'b1);
                loadTx(8'h22);
                cnt = 0;
                while (!rx_valid && cnt < 400) begin
                    @(negedge clk);
                    cnt++;
                end
                checkRx();
                ackRx();
            end
        join
        checkRx();
        checkOutput("overrunB2B", overrun, 1'b0);
        ackRx();

        $display("[TB] abort then clean transfer");
        setMode(1'b0, 1'b0);
        loadTx(8'h5A);
        ss = 1'b0;
        #(HALF);
        spiByte(8'h3F, 4, r);
        #(HALF);
        ss = 1'b1;
        #(HALF);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortRxValid", rx_valid, 1'b0);
        checkOutput("abortOverrun", overrun, 1'b0);
        expMaster.push_back(8'h5A);
        expRx.push_back(8'hC3);
        txBytes[0] = 8'hC3;
        applyStimulus(1);
        checkRx();
        ackRx();

        $display("[TB] overrun");
        expMaster.push_back(8'h5A);
        expRx.push_back(8'h55);
        txBytes[0] = 8'h55;
        applyStimulus(1);
        checkRx();
        checkOutput("overrunFirst", overrun, 1'b0);
        expMaster.push_back(8'h5A);
        expRx.push_back(8'hAA);
        txBytes[0] = 8'hAA;
        applyStimulus(1);
        checkRx();
        checkOutput("overrunSet", overrun, 1'b1);
        ackRx();
        checkOutput("overrunSticky", overrun, 1'b1);

        $display("[TB] async reset mid-byte");
        loadTx(8'hFF);
        ss = 1'b0;
        #(HALF);
        spiByte(8'hFF, 4, r);
        #30;
        checkOutput("preRstBusy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arstMiso", miso, 1'b0);
        checkOutput("arstMisoOe", miso_oe, 1'b0);
        checkOutput("arstTxReady", tx_ready, 1'b1);
        checkOutput("arstRxData", rx_data, 8'h00);
        checkOutput("arstRxValid", rx_valid, 1'b0);
        checkOutput("arstBusy", busy, 1'b0);
        checkOutput("arstOverrun", overrun, 1'b0);
        #7;
        ss = 1'b1;
        #20;
        rst = 1'b0;
        #(HALF);
        loadTx(8'h96);
        expMaster.push_back(8'h96);
        expRx.push_back(8'h3C);
        txBytes[0] = 8'h3C;
        applyStimulus(1);
        checkRx();
        checkOutput("overrunAfterRst", overrun, 1'b0);
        ackRx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) endpoint: the far end of an 8-bit SPI master link.
- Oversamples the external sclk/ss/mosi lines with the system clk, so no second clock domain exists.
- Shifts a full-duplex byte and supports all four CPOL/CPHA modes.
- Exchanges bytes with local logic through a single-entry TX buffer and a held RX register with acknowledge.

Parameters:
- DATA_W, 8, bits per transfer.
- SYNC_STAGES, 2, synchronizer flops on sclk, ss and mosi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst  input  1  asynchronous active-high reset.
- cpol  input  1  sclk idle level.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
- sclk  input  1  serial clock from the master.
- ss  input  1  active-low select from the master.
- mosi  input  1  serial data in.
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  high while selected; external tristate enable.
- tx_data  input  DATA_W  byte to send in the next transfer.
- tx_load  input  1  one-cycle pulse that writes tx_data into the TX buffer.
- tx_ready  output  1  TX buffer empty and able to accept tx_load.
- rx_data  output  DATA_W  last received byte.
- rx_valid  output  1  rx_data holds an unacknowledged byte.
- rx_ack  input  1  one-cycle pulse that clears rx_valid.
- busy  output  1  high while in ACTIVE.
- overrun  output  1  sticky; a byte completed while rx_valid was still high.

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0.
  - tx_buf=0, shift registers=0, bit_cnt=0, state=IDLE, all synchronizer flops at their idle values (ss=1, sclk=0).
  - Reset mid-transfer aborts immediately to these values.
- Synchronization and edge detection:
  - sclk, ss and mosi each pass through SYNC_STAGES flops.
  - One further flop on sync sclk provides edge detection.
  - Input-to-action latency is SYNC_STAGES+1 clk.
- Edge definitions:
  - Leading edge: sync sclk leaves the level cpol_l.
  - Trailing edge: sync sclk returns to cpol_l.
  - Sample edge: leading if cpha_l=0, trailing if cpha_l=1. Shift edge is the other one.
- IDLE state:
  - miso_oe=0, busy=0.
  - On a falling edge of sync ss:
    - latch cpha_l and cpol_l;
    - copy tx_buf into tx_shift and set tx_ready=1;
    - clear bit_cnt;
    - go to ACTIVE.
  - If cpha_l=0, miso=tx_shift MSB in the same cycle.
- ACTIVE state:
  - miso_oe=1, busy=1.
  - Sample edge: rx_shift <= {rx_shift[DATA_W-2:0], sync mosi}; bit_cnt <= bit_cnt+1.
  - Shift edge, cpha_l=0: shift tx_shift left and put the new MSB on miso. This is skipped after the final sample of a byte; the reload covers it.
  - Shift edge, cpha_l=1: put the current tx_shift MSB on miso, then shift left.
  - On the DATA_W-th sample:
    - rx_data <= completed byte; rx_valid <= 1;
    - if rx_valid was already 1 and rx_ack is not asserted in the same cycle, overrun <= 1 and rx_data is overwritten;
    - bit_cnt wraps to 0;
    - tx_shift reloads from tx_buf and tx_ready <= 1 (back-to-back bytes while ss stays low);
    - if cpha_l=0, miso takes the reloaded MSB in the same cycle.
  - On a rising edge of sync ss, go to IDLE:
    - a partial byte is discarded, with no rx_valid and no overrun;
    - miso_oe=0 in the following cycle.
- TX buffer:
  - tx_load while tx_ready=1: tx_buf <= tx_data, tx_ready <= 0.
  - tx_load while tx_ready=0 is ignored.
  - If tx_buf is consumed without a new load, the same byte is sent again.
  - tx_load in the same cycle as a buffer-to-shift copy: the copy uses the old tx_buf, then the load is accepted and tx_ready ends 0.
- RX acknowledge:
  - rx_ack clears rx_valid.
  - rx_ack in the same cycle as byte completion: rx_valid stays 1 with the new byte, and overrun is not set.
  - overrun clears only on rst.
- Timing and mode rules:
  - The master must hold ss low for at least SYNC_STAGES+2 clk before the first sclk edge.
  - sclk high and low phases must each be at least 4 clk.
  - cpol and cpha are ignored outside IDLE.

Test Plan:
- Mode 0: tx_load 0x3C, master sends 0xA5 -> master receives 0x3C; rx_data=0xA5; rx_valid rises within SYNC_STAGES+2 clk after the 8th rising sclk edge.
- Mode 3 (cpol=1, cpha=1): tx 0x81, master sends 0x7E -> master receives 0x81; rx_data=0x7E; miso_oe=1 only while ss is low.
- Back-to-back in mode 1: load 0x11, then load 0x22 once tx_ready rises during byte 1; master sends 0xF0,0x0F with no ss gap -> master receives 0x11,0x22; rx_valid for 0xF0 is acked before byte 2 ends; overrun=0.
- Abort: ss rises after 4 sclk cycles -> busy=0 and rx_valid=0; the next full transfer of 0xC3 gives rx_data=0xC3 and is not corrupted by the partial bits.
- Overrun: two bytes 0x55,0xAA with no rx_ack -> rx_data=0xAA, overrun=1; rx_ack then clears rx_valid but overrun stays 1.
- Reset: assert rst asynchronously mid-byte -> all outputs take their reset values immediately, without waiting for a clk edge; after release a clean transfer works.
